// File: rtl/uart_pkg.sv
// Shared constants for the UART TX scheduler: FSM encodings, default frame shape, and a
// constant-foldable clog2 used to size ports and counters.
package uart_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int unsigned DEF_DATA_BITS = 8;
    localparam int unsigned DEF_STOP_BITS = 1;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr, wrapping,
// so the last winner gets the lowest priority on the next scan.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               valid_c
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!valid_c && req[cand]) begin
                valid_c     = 1'b1;
                idx_c       = cand;
                gnt_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART TX line between NUM_REQ byte producers; sends
// start / DATA_BITS LSB-first / STOP_BITS frames, one bit per rising edge of baud_clk.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned STOP_BITS = DEF_STOP_BITS,
    localparam int unsigned IDX_W = clog2(NUM_REQ)
) (
    input  logic                           clk_in,
    input  logic                           rst,
    input  logic                           baud_clk,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [IDX_W-1:0]               owner,
    output logic                           busy,
    output logic                           tx
);

    localparam int unsigned BIT_CNT_W  = clog2(DATA_BITS + 1);
    localparam int unsigned STOP_CNT_W = clog2(STOP_BITS + 1);

    logic [1:0]            state_q, state_d;
    logic                  baud_q;
    logic                  tick_c;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [STOP_CNT_W-1:0] stop_cnt_q, stop_cnt_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    grant_d;
    logic [IDX_W-1:0]      owner_d;
    logic                  busy_d;
    logic                  tx_d;

    logic [NUM_REQ-1:0]    arb_gnt_c;
    logic [IDX_W-1:0]      arb_idx_c;
    logic                  arb_valid_c;
    logic [DATA_BITS-1:0]  data_arr [NUM_REQ];

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign data_arr[g] = data[g*DATA_BITS +: DATA_BITS];
    end

    // baud_clk is synchronous to clk_in, so a single register suffices for edge detection.
    assign tick_c = baud_clk & ~baud_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_c   (arb_gnt_c),
        .idx_c   (arb_idx_c),
        .valid_c (arb_valid_c)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            grant      <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_clk;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            ptr_q      <= ptr_d;
            grant      <= grant_d;
            owner      <= owner_d;
            busy       <= busy_d;
            tx         <= tx_d;
        end
    end

    // Next-state and next-output logic; ticks are only acted on once a frame is owned.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        ptr_d      = ptr_q;
        grant_d    = '0;
        owner_d    = owner;
        busy_d     = busy;
        tx_d       = tx;

        case (state_q)
            S_IDLE: begin
                if (arb_valid_c) begin
                    shift_d = data_arr[arb_idx_c];
                    grant_d = arb_gnt_c;
                    owner_d = arb_idx_c;
                    ptr_d   = arb_idx_c;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_c) begin
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        stop_cnt_d = '0;
                        state_d    = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // First tick raises the line; the frame ends STOP_BITS periods later.
                if (tick_c) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = stop_cnt_q + STOP_CNT_W'(1);
                    if (stop_cnt_q == STOP_CNT_W'(STOP_BITS)) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
